// File: rtl/muldiv_issue_ctrl.sv
// rtl/muldiv_issue_ctrl.sv - issue/writeback controller for the multi-cycle M-extension unit
module muldiv_issue_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic        dec_is_muldiv,
  input  logic [5:0]  dec_alucode,
  input  logic [31:0] dec_op1,
  input  logic [31:0] dec_op2,
  input  logic [4:0]  dec_rd,
  input  logic        dec_rd_we,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_rs1_used,
  input  logic        dec_rs2_used,
  input  logic        flush,
  output logic        mc_is_multiclock,
  output logic [5:0]  mc_alucode,
  output logic [31:0] mc_op1,
  output logic [31:0] mc_op2,
  input  logic [31:0] mc_result,
  input  logic        mc_done,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ready,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_DRAIN
  } state_t;

  state_t         state_q, state_d;
  logic [5:0]     alucode_q, alucode_d;
  logic [31:0]    op1_q, op1_d;
  logic [31:0]    op2_q, op2_d;
  logic [4:0]     rd_q, rd_d;
  logic [31:0]    data_q, data_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  logic [CW-1:0]  cnt_inc;
  logic           cnt_hit;
  logic           hazard;

  // Saturating next count and the timeout condition it produces
  always_comb begin
    cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
    cnt_hit = (cnt_inc == CW'(TIMEOUT));
  end

  // Read-after-write and write-after-write hazard against the in-flight destination
  always_comb begin
    hazard = (rd_q != 5'd0) &&
             ((dec_rs1_used && (dec_rs1 == rd_q)) ||
              (dec_rs2_used && (dec_rs2 == rd_q)) ||
              (dec_rd_we    && (dec_rd  == rd_q)));
    stall  = dec_valid && !flush && (state_q != S_IDLE) && (dec_is_muldiv || hazard);
  end

  // Next-state and datapath capture; flush outranks mc_done, mc_done outranks timeout
  always_comb begin
    state_d   = state_q;
    alucode_d = alucode_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    rd_d      = rd_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dec_valid && dec_is_muldiv && !flush) begin
          alucode_d = dec_alucode;
          op1_d     = dec_op1;
          op2_d     = dec_op2;
          rd_d      = dec_rd_we ? dec_rd : 5'd0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else if (mc_done) begin
          data_d  = mc_result;
          state_d = (rd_q != 5'd0) ? S_WB : S_IDLE;
        end else if (cnt_hit) begin
          cnt_d   = cnt_inc;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      S_WB: begin
        if (flush || wb_ready) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_inc;
        if (mc_done || cnt_hit) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      alucode_q <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      rd_q      <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      alucode_q <= alucode_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign mc_is_multiclock = (state_q == S_ISSUE);
  assign mc_alucode       = alucode_q;
  assign mc_op1           = op1_q;
  assign mc_op2           = op2_q;
  assign wb_valid         = (state_q == S_WB);
  assign wb_rd            = rd_q;
  assign wb_data          = data_q;
  assign busy             = (state_q != S_IDLE);
  assign err              = err_q;

endmodule
